div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter W, default 8, meaning operand and result width in bits; legal range 2..32.
REQ-002 Port clk  input  1  meaning the single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  meaning reset, asynchronous and active-high.
REQ-004 Port start  input  1  meaning request a division; sampled on rising clk.
REQ-005 Port signed_mode  input  1  meaning 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 Port D  input  W  meaning dividend; sampled with start.
REQ-007 Port divider  input  W  meaning divisor; sampled with start.
REQ-008 Port q  output  W  meaning quotient, registered.
REQ-009 Port r  output  W  meaning remainder, registered.
REQ-010 Port busy  output  1  meaning a division is in progress.
REQ-011 Port valid  output  1  meaning q, r and dbz hold the result of the last accepted start.
REQ-012 Port dbz  output  1  meaning the last accepted division had divider == 0.

Function
REQ-013 The block SHALL implement states IDLE, CALC, FIX and DONE.
REQ-014 start SHALL be accepted only in IDLE or DONE; in CALC or FIX it SHALL be ignored with no effect.
REQ-015 On acceptance, the block SHALL capture D, divider and signed_mode, clear valid and dbz on the same edge, and later input changes SHALL have no effect.
REQ-016 Acceptance with divider != 0 SHALL enter CALC with an iteration counter = W-1 and busy = 1.
REQ-017 Acceptance with divider == 0 SHALL go directly to DONE, with q = all ones, r = D, dbz = 1, valid = 1 and busy = 0 on the same edge.
REQ-018 In signed mode, operand magnitudes SHALL be used for the iterations; in unsigned mode, the raw operands SHALL be used.
REQ-019 CALC SHALL perform restoring division, one quotient bit per cycle, MSB first, using a 2W-bit partial remainder so that no intermediate overflows.
REQ-020 CALC SHALL last exactly W cycles, with the counter decrementing each cycle; after the edge with counter == 0 the state SHALL be FIX.
REQ-021 FIX SHALL last one cycle and apply signs: q negated if the dividend and divisor signs differ, r negated if the dividend is negative (quotient truncates toward zero; remainder takes the dividend's sign).
REQ-022 In signed mode, the case most-negative / -1 SHALL yield q = most-negative value (wrap) and r = 0, with no flag.
REQ-023 FIX SHALL go to DONE, setting valid = 1 and busy = 0 with q and r final on that edge.
REQ-024 For a non-zero divider, the latency SHALL be W+1 rising edges from the accepting edge to the edge that asserts valid.
REQ-025 DONE SHALL hold q, r, valid and dbz stable until the next accepted start or reset.
REQ-026 start asserted in DONE SHALL restart immediately; valid SHALL be 0 from that edge.
REQ-027 q and r SHALL not be guaranteed meaningful while busy = 1; they SHALL only be used when valid = 1.
REQ-028 busy and valid SHALL never be 1 simultaneously.

Reset
REQ-029 rst = 1 SHALL immediately, without waiting for clk, force state IDLE, q = 0, r = 0, busy = 0, valid = 0, dbz = 0 and counter = 0.
REQ-030 A reset mid-operation SHALL abort the division with no result; the first start after rst is released SHALL behave as from power-up.
REQ-031 While rst = 1, start SHALL be ignored.

Verification
REQ-032 W=8, unsigned, D=100, divider=7 -> valid rises 9 edges after accept; q=14 (0x0E), r=2; busy high for exactly 9 cycles.
REQ-033 W=8, signed, D=0xF9 (-7), divider=2 -> q=0xFD (-3), r=0xFF (-1); W=8, signed, D=0x80, divider=0xFF -> q=0x80, r=0x00.
REQ-034 W=8, D=5, divider=0 (either mode) -> the next edge gives q=0xFF, r=0x05, dbz=1, valid=1, busy=0.
REQ-035 A second start with new operands 3 cycles into CALC -> ignored; the result equals the first operands; then start in DONE gives valid=0 on the next edge and the new result 9 edges later.
REQ-036 rst pulsed asynchronously mid-CALC -> all outputs zero before the next clk edge; then a division of 255/16 (unsigned) gives q=15, r=15.
REQ-037 Randomised check, W=4 and W=16, both modes, divider != 0 -> q*divider + r == D, with |r| < |divider| and the sign of r equal to the sign of D (or r = 0).

Source files
------------

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per clock, with optional
// two's-complement operands and a divide-by-zero shortcut.
module div_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [W-1:0] D,
    input  logic [W-1:0] divider,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         busy,
    output logic         valid,
    output logic         dbz,
    output logic [1:0]   dbg_state
);
    // Handshake: start is sampled on each rising clk and accepted only in IDLE or DONE.
    // valid drops on the accepting edge and rises once q/r/dbz are final; busy and valid are exclusive.
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_pr;
    logic [W-1:0]   r_dv;
    logic           r_neg_q;
    logic           r_neg_r;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_r;
    logic           r_busy;
    logic           r_valid;
    logic           r_dbz;

    logic           w_accept;
    logic [W-1:0]   w_d_mag;
    logic [W-1:0]   w_dv_mag;
    logic [2*W:0]   w_shift;
    logic [W:0]     w_hi;
    logic [W:0]     w_sub;
    logic           w_ge;
    logic [2*W-1:0] w_pr_next;

    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_d_mag  = (signed_mode && D[W-1]) ? -D : D;
    assign w_dv_mag = (signed_mode && divider[W-1]) ? -divider : divider;

    // The shifted remainder needs W+1 bits: it can reach 2*divisor-1 before the subtract.
    assign w_shift   = {r_pr, 1'b0};
    assign w_hi      = w_shift[2*W:W];
    assign w_ge      = (w_hi >= {1'b0, r_dv});
    assign w_sub     = w_hi - {1'b0, r_dv};
    assign w_pr_next = {(w_ge ? w_sub[W-1:0] : w_hi[W-1:0]), w_shift[W-1:1], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next = (divider == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_cnt == '0) begin
                    w_next = FIX;
                end
            end
            FIX:     w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_pr    <= '0;
            r_dv    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        if (divider == '0) begin
                            r_q     <= '1;
                            r_r     <= D;
                            r_dbz   <= 1'b1;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt   <= CW'(W - 1);
                            r_pr    <= {{W{1'b0}}, w_d_mag};
                            r_dv    <= w_dv_mag;
                            r_neg_q <= signed_mode && (D[W-1] ^ divider[W-1]);
                            r_neg_r <= signed_mode && D[W-1];
                            r_dbz   <= 1'b0;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_pr <= w_pr_next;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                FIX: begin
                    // Most-negative / -1 wraps naturally: its magnitude quotient is already 2^(W-1).
                    r_q     <= r_neg_q ? -r_pr[W-1:0] : r_pr[W-1:0];
                    r_r     <= r_neg_r ? -r_pr[2*W-1:W] : r_pr[2*W-1:W];
                    r_busy  <= 1'b0;
                    r_valid <= 1'b1;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign q         = r_q;
    assign r         = r_r;
    assign busy      = r_busy;
    assign valid     = r_valid;
    assign dbz       = r_dbz;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: W=8 main instance plus W=4 and W=16 instances.
module tb_div_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // W=8 instance
    logic       start = 1'b0, sm = 1'b0;
    logic [7:0] d = '0, dv = '0;
    logic [7:0] q, r;
    logic       busy, valid, dbz;
    logic [1:0] st;

    div_seq #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .D(d), .divider(dv),
        .q(q), .r(r), .busy(busy), .valid(valid), .dbz(dbz), .dbg_state(st)
    );

    // W=4 instance
    logic       s4 = 1'b0, m4 = 1'b0;
    logic [3:0] d4 = '0, v4 = '0;
    logic [3:0] q4, r4;
    logic       busy4, valid4, dbz4;
    logic [1:0] st4;

    div_seq #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4), .signed_mode(m4), .D(d4), .divider(v4),
        .q(q4), .r(r4), .busy(busy4), .valid(valid4), .dbz(dbz4), .dbg_state(st4)
    );

    // W=16 instance
    logic        s16 = 1'b0, m16 = 1'b0;
    logic [15:0] d16 = '0, v16 = '0;
    logic [15:0] q16, r16;
    logic        busy16, valid16, dbz16;
    logic [1:0]  st16;

    div_seq #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .start(s16), .signed_mode(m16), .D(d16), .divider(v16),
        .q(q16), .r(r16), .busy(busy16), .valid(valid16), .dbz(dbz16), .dbg_state(st16)
    );

    // Drives one start pulse; returns at the negedge after the accepting edge.
    // Operands are scrambled afterwards so a design that fails to capture them shows up.
    task automatic issue8(input logic m, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1; sm = m; d = a; dv = b;
        @(negedge clk);
        start = 1'b0; sm = ~m;
        d = 8'($urandom_range(0, 255));
        dv = 8'($urandom_range(1, 255));
    endtask

    // Counts edges until valid (-1 on timeout) and the busy cycles seen on the way.
    task automatic wait_valid(output int edges, output int bcnt);
        edges = -1;
        bcnt = 0;
        for (int n = 1; n <= 40; n++) begin
            if (busy) bcnt++;
            @(negedge clk);
            if (valid) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #3;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h exp 00", q); end
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_r: got %h exp 00", r); end
        checks++; if ({busy, valid, dbz} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {busy, valid, dbz}); end
        checks++; if (st !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", st); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        int e, b;
        issue8(1'b0, 8'd100, 8'd7);
        wait_valid(e, b);
        checks++; if (e !== 9) begin errors++; $display("FAIL u_latency: got %0d exp 9", e); end
        checks++; if (b !== 9) begin errors++; $display("FAIL u_busy_cycles: got %0d exp 9", b); end
        checks++; if (q !== 8'h0E) begin errors++; $display("FAIL u_q: got %h exp 0e", q); end
        checks++; if (r !== 8'h02) begin errors++; $display("FAIL u_r: got %h exp 02", r); end
        checks++; if ({busy, dbz} !== 2'b00) begin errors++; $display("FAIL u_busy_dbz: got %b exp 00", {busy, dbz}); end
        repeat (3) @(negedge clk);
        checks++; if ({valid, q, r} !== {1'b1, 8'h0E, 8'h02}) begin errors++; $display("FAIL u_hold: got %b/%h/%h exp 1/0e/02", valid, q, r); end
    endtask

    task automatic test_signed();
        logic [7:0] td [0:3] = '{8'hF9, 8'h80, 8'h07, 8'hF9};
        logic [7:0] tv [0:3] = '{8'h02, 8'hFF, 8'hFE, 8'hFE};
        logic [7:0] tq [0:3] = '{8'hFD, 8'h80, 8'hFD, 8'h03};
        logic [7:0] tr [0:3] = '{8'hFF, 8'h00, 8'h01, 8'hFF};
        int e, b;
        for (int i = 0; i < 4; i++) begin
            issue8(1'b1, td[i], tv[i]);
            wait_valid(e, b);
            checks++; if (e !== 9) begin errors++; $display("FAIL s_latency[%0d]: got %0d exp 9", i, e); end
            checks++; if (q !== tq[i]) begin errors++; $display("FAIL s_q[%0d]: got %h exp %h", i, q, tq[i]); end
            checks++; if (r !== tr[i]) begin errors++; $display("FAIL s_r[%0d]: got %h exp %h", i, r, tr[i]); end
            checks++; if ({busy, dbz} !== 2'b00) begin errors++; $display("FAIL s_flags[%0d]: got %b exp 00", i, {busy, dbz}); end
        end
    endtask

    task automatic test_dbz();
        int e, b;
        for (int m = 0; m < 2; m++) begin
            issue8(1'(m), 8'd5, 8'd0);
            checks++; if ({q, r} !== {8'hFF, 8'h05}) begin errors++; $display("FAIL dbz_qr[%0d]: got %h/%h exp ff/05", m, q, r); end
            checks++; if ({dbz, valid, busy} !== 3'b110) begin errors++; $display("FAIL dbz_flags[%0d]: got %b exp 110", m, {dbz, valid, busy}); end
            checks++; if (st !== 2'd3) begin errors++; $display("FAIL dbz_state[%0d]: got %0d exp 3", m, st); end
        end
        issue8(1'b0, 8'd9, 8'd3);
        checks++; if ({dbz, valid, busy} !== 3'b001) begin errors++; $display("FAIL dbz_clear: got %b exp 001", {dbz, valid, busy}); end
        wait_valid(e, b);
        checks++; if ({q, r} !== {8'h03, 8'h00}) begin errors++; $display("FAIL dbz_after_qr: got %h/%h exp 03/00", q, r); end
    endtask

    task automatic test_ignore_start();
        int e, b;
        issue8(1'b0, 8'd200, 8'd10);
        repeat (2) @(negedge clk);
        start = 1'b1; sm = 1'b1; d = 8'd50; dv = 8'd3;
        @(negedge clk);
        start = 1'b0;
        wait_valid(e, b);
        checks++; if (3 + e !== 9) begin errors++; $display("FAIL ign_latency: got %0d exp 9", 3 + e); end
        checks++; if ({q, r} !== {8'd20, 8'd0}) begin errors++; $display("FAIL ign_qr: got %h/%h exp 14/00", q, r); end
    endtask

    task automatic test_back_to_back();
        int e, b;
        issue8(1'b0, 8'd50, 8'd3);
        checks++; if ({valid, busy} !== 2'b01) begin errors++; $display("FAIL b2b_restart: got %b exp 01", {valid, busy}); end
        wait_valid(e, b);
        checks++; if (e !== 9) begin errors++; $display("FAIL b2b_latency: got %0d exp 9", e); end
        checks++; if ({q, r} !== {8'd16, 8'd2}) begin errors++; $display("FAIL b2b_qr: got %h/%h exp 10/02", q, r); end
    endtask

    task automatic test_reset_mid();
        int e, b;
        issue8(1'b0, 8'd100, 8'd7);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if ({q, r} !== 16'h0000) begin errors++; $display("FAIL rmid_qr: got %h/%h exp 00/00", q, r); end
        checks++; if ({busy, valid, dbz, st} !== 5'b0) begin errors++; $display("FAIL rmid_flags: got %b exp 00000", {busy, valid, dbz, st}); end
        start = 1'b1; d = 8'd40; dv = 8'd4;
        @(negedge clk);
        checks++; if ({busy, st} !== 3'b0) begin errors++; $display("FAIL rst_start_ignored: got %b exp 000", {busy, st}); end
        start = 1'b0;
        rst = 1'b0;
        issue8(1'b0, 8'd255, 8'd16);
        wait_valid(e, b);
        checks++; if (e !== 9) begin errors++; $display("FAIL rmid_latency: got %0d exp 9", e); end
        checks++; if ({q, r} !== {8'd15, 8'd15}) begin errors++; $display("FAIL rmid_qr_after: got %h/%h exp 0f/0f", q, r); end
    endtask

    task automatic test_w4();
        logic       tm [0:2] = '{1'b0, 1'b1, 1'b1};
        logic [3:0] td [0:2] = '{4'd13, 4'h8, 4'h7};
        logic [3:0] tv [0:2] = '{4'd4, 4'h3, 4'hD};
        logic [3:0] tq [0:2] = '{4'd3, 4'hE, 4'hE};
        logic [3:0] tr [0:2] = '{4'd1, 4'hE, 4'h1};
        int lat;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s4 = 1'b1; m4 = tm[i]; d4 = td[i]; v4 = tv[i];
            @(negedge clk);
            s4 = 1'b0;
            lat = -1;
            for (int n = 1; n <= 20; n++) begin
                @(negedge clk);
                if (valid4) begin lat = n; break; end
            end
            checks++; if (lat !== 5) begin errors++; $display("FAIL w4_latency[%0d]: got %0d exp 5", i, lat); end
            checks++; if ({q4, r4} !== {tq[i], tr[i]}) begin errors++; $display("FAIL w4_qr[%0d]: got %h/%h exp %h/%h", i, q4, r4, tq[i], tr[i]); end
        end
    endtask

    task automatic test_w16();
        logic        tm [0:2] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] td [0:2] = '{16'hEA60, 16'h8AD0, 16'h8000};
        logic [15:0] tv [0:2] = '{16'd7, 16'd123, 16'hFFFF};
        logic [15:0] tq [0:2] = '{16'h217B, 16'hFF0D, 16'h8000};
        logic [15:0] tr [0:2] = '{16'h0003, 16'hFF91, 16'h0000};
        int lat;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s16 = 1'b1; m16 = tm[i]; d16 = td[i]; v16 = tv[i];
            @(negedge clk);
            s16 = 1'b0;
            lat = -1;
            for (int n = 1; n <= 40; n++) begin
                @(negedge clk);
                if (valid16) begin lat = n; break; end
            end
            checks++; if (lat !== 17) begin errors++; $display("FAIL w16_latency[%0d]: got %0d exp 17", i, lat); end
            checks++; if ({q16, r16} !== {tq[i], tr[i]}) begin errors++; $display("FAIL w16_qr[%0d]: got %h/%h exp %h/%h", i, q16, r16, tq[i], tr[i]); end
            checks++; if (dbz16 !== 1'b0) begin errors++; $display("FAIL w16_dbz[%0d]: got %b exp 0", i, dbz16); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_dbz();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_w4();
        test_w16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
